// File: rtl/unified_mem_arbiter_pkg.sv
// rtl/unified_mem_arbiter_pkg.sv - shared types and constants for the unified memory arbiter
// Purpose: sequencer state enum, port-owner enum and the word funct3 used for fetches.
// Ports: none (package).
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } arb_state_e;

  typedef enum logic {
    OWN_FETCH,
    OWN_DATA
  } owner_e;

  // Instruction fetches are always full 32-bit words.
  localparam logic [2:0] FUNCT3_WORD = 3'b010;

endpackage

// File: rtl/unified_mem_arbiter_mem_lat_counter.sv
// rtl/unified_mem_arbiter_mem_lat_counter.sv - loadable 3-bit down-counter timing the memory latency
// Purpose: loaded with LAT-1 while the command is issued, counts down while waiting for read data.
// Ports: clk_i, rst_i (async, active-high), load_i/load_val_i (load), dec_i (decrement), zero_o (count is 0).
module mem_lat_counter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [2:0] load_val_i,
  input  logic       dec_i,
  output logic       zero_o
);

  logic [2:0] cnt_q;
  logic [2:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != 3'd0)) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 3'd0);

endmodule

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - arbiter/sequencer for the shared RV32 instruction/data memory port
// Purpose: grants the single memory port to IF fetches or MEM loads/stores, issues one registered
//   command, waits LAT cycles, returns registered read data with a one-cycle ack.
// Ports: clk_i, rst_i (async, active-high);
//   if_req_i/if_addr_i -> if_ack_o/if_rdata_o/if_stall_o (fetch side);
//   d_req_i/d_we_i/d_func_i/d_addr_i/d_wdata_i -> d_ack_o/d_rdata_o/d_stall_o (data side);
//   m_en_o/m_we_o/m_func_o/m_addr_o/m_wdata_o -> memory, m_rdata_i <- memory.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int LAT        = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_ack_o,
  output logic [DW-1:0] if_rdata_o,
  output logic          if_stall_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [2:0]    d_func_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic          d_ack_o,
  output logic [DW-1:0] d_rdata_o,
  output logic          d_stall_o,
  output logic          m_en_o,
  output logic          m_we_o,
  output logic [2:0]    m_func_o,
  output logic [AW-1:0] m_addr_o,
  output logic [DW-1:0] m_wdata_o,
  input  logic [DW-1:0] m_rdata_i
);

  localparam logic [2:0] LAT_LOAD   = 3'(LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arb_state_e    state_q;
  owner_e        owner_q;
  logic [3:0]    starve_q, starve_d;
  logic          m_en_q, m_we_q;
  logic [2:0]    m_func_q;
  logic [AW-1:0] m_addr_q;
  logic [DW-1:0] m_wdata_q;
  logic          if_ack_q, d_ack_q;
  logic [DW-1:0] if_rdata_q, d_rdata_q;

  logic arb_en, if_elig, d_elig, grant_if, grant_d, lat_zero;

  // In RESP the owner is still holding its request for the access being acked,
  // so it is masked to avoid issuing that access a second time.
  always_comb begin
    arb_en   = (state_q == ST_IDLE) || (state_q == ST_RESP);
    if_elig  = if_req_i && !((state_q == ST_RESP) && (owner_q == OWN_FETCH));
    d_elig   = d_req_i && !((state_q == ST_RESP) && (owner_q == OWN_DATA));
    grant_if = arb_en && if_elig && (!d_elig || (starve_q == STARVE_LIM));
    grant_d  = arb_en && d_elig && !grant_if;

    starve_d = starve_q;
    if (grant_if) begin
      starve_d = 4'd0;
    end else if (grant_d && if_req_i && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  mem_lat_counter u_lat_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (state_q == ST_ISSUE),
    .load_val_i (LAT_LOAD),
    .dec_i      (state_q == ST_WAIT),
    .zero_o     (lat_zero)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_FETCH;
      starve_q   <= 4'd0;
      m_en_q     <= 1'b0;
      m_we_q     <= 1'b0;
      m_func_q   <= 3'd0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      m_en_q   <= 1'b0;
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      starve_q <= starve_d;
      unique case (state_q)
        ST_IDLE, ST_RESP: begin
          if (grant_if) begin
            owner_q   <= OWN_FETCH;
            m_we_q    <= 1'b0;
            m_func_q  <= FUNCT3_WORD;
            m_addr_q  <= if_addr_i;
            m_wdata_q <= '0;
            m_en_q    <= 1'b1;
            state_q   <= ST_ISSUE;
          end else if (grant_d) begin
            owner_q   <= OWN_DATA;
            m_we_q    <= d_we_i;
            m_func_q  <= d_func_i;
            m_addr_q  <= d_addr_i;
            m_wdata_q <= d_wdata_i;
            m_en_q    <= 1'b1;
            state_q   <= ST_ISSUE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (lat_zero) begin
            state_q <= ST_RESP;
            if (owner_q == OWN_FETCH) begin
              if_rdata_q <= m_rdata_i;
              if_ack_q   <= 1'b1;
            end else begin
              if (!m_we_q) begin
                d_rdata_q <= m_rdata_i;
              end
              d_ack_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_en_o     = m_en_q;
  assign m_we_o     = m_we_q;
  assign m_func_o   = m_func_q;
  assign m_addr_o   = m_addr_q;
  assign m_wdata_o  = m_wdata_q;
  assign if_ack_o   = if_ack_q;
  assign d_ack_o    = d_ack_q;
  assign if_rdata_o = if_rdata_q;
  assign d_rdata_o  = d_rdata_q;
  assign if_stall_o = if_req_i & ~if_ack_q;
  assign d_stall_o  = d_req_i & ~d_ack_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - self-checking bench for unified_mem_arbiter
module tb_unified_mem_arbiter;

  localparam int LAT  = 3;
  localparam int SMAX = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, m_rdata;
  logic [2:0]  d_func;
  logic        if_ack, if_stall, d_ack, d_stall, m_en, m_we;
  logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
  logic [2:0]  m_func;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.AW(32), .DW(32), .LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_rdata_o(if_rdata), .if_stall_o(if_stall),
    .d_req_i(d_req), .d_we_i(d_we), .d_func_i(d_func), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_ack_o(d_ack), .d_rdata_o(d_rdata), .d_stall_o(d_stall),
    .m_en_o(m_en), .m_we_o(m_we), .m_func_o(m_func), .m_addr_o(m_addr), .m_wdata_o(m_wdata),
    .m_rdata_i(m_rdata)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] sched [int];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; act as the memory: reads return LAT cycles after the m_en cycle,
  // random garbage is driven on every other cycle.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    m_rdata = sched.exists(cyc) ? sched[cyc] : $urandom;
    if (m_en === 1'b1) begin
      if (m_we) mem[m_addr] = m_wdata;
      else sched[cyc + LAT] = mem.exists(m_addr) ? mem[m_addr] : 32'hBAD0_0000;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_m_en"}, m_en, 0);
    chk({tag, "_m_we"}, m_we, 0);
    chk({tag, "_m_func"}, m_func, 0);
    chk({tag, "_m_addr"}, m_addr, 0);
    chk({tag, "_m_wdata"}, m_wdata, 0);
    chk({tag, "_if_ack"}, if_ack, 0);
    chk({tag, "_d_ack"}, d_ack, 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic        exp_f, exp_d, take_f, ef, ed, f_act, d_act;
  logic        mbusy, mwe, mown;
  logic [31:0] maddr, mwdata, v;
  logic [2:0]  mfunc;
  int          mgrant, mdone, mask, starve, ack_n;

  initial begin
    rst = 1'b1; if_req = 0; d_req = 0; d_we = 0; d_func = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; m_rdata = 0;
    tick(); tick();
    chk_all_zero("reset");
    chk("reset_if_stall", if_stall, 0);
    chk("reset_d_stall", d_stall, 0);
    rst = 1'b0;
    tick();

    // Fetch only
    mem[32'h10] = 32'h0050_0093;
    tick();
    if_req = 1; if_addr = 32'h10; #1;
    chk("f_stall_c0", if_stall, 1);
    tick();
    chk("f_m_en_c1", m_en, 1); chk("f_m_addr", m_addr, 32'h10);
    chk("f_m_we", m_we, 0); chk("f_m_func", m_func, 3'b010); chk("f_stall_c1", if_stall, 1);
    for (int i = 2; i <= LAT + 1; i++) begin
      tick();
      chk("f_m_en_wait", m_en, 0); chk("f_ack_wait", if_ack, 0); chk("f_stall_wait", if_stall, 1);
    end
    tick();
    chk("f_ack", if_ack, 1); chk("f_rdata", if_rdata, 32'h0050_0093); chk("f_stall_ack", if_stall, 0);
    if_req = 0;
    tick();
    chk("f_ack_pulse", if_ack, 0); chk("f_rdata_held", if_rdata, 32'h0050_0093);

    // Simultaneous load + fetch: data first
    mem[32'h40] = 32'h1234_5678; mem[32'h14] = 32'h00a0_0113;
    tick();
    if_req = 1; if_addr = 32'h14;
    d_req = 1; d_we = 0; d_func = 3'b100; d_addr = 32'h40; d_wdata = $urandom;
    tick();
    chk("s_m_en_data", m_en, 1); chk("s_m_addr_data", m_addr, 32'h40); chk("s_m_func_data", m_func, 3'b100);
    repeat (LAT) tick();
    tick();
    chk("s_d_ack", d_ack, 1); chk("s_d_rdata", d_rdata, 32'h1234_5678);
    chk("s_if_ack_early", if_ack, 0); chk("s_if_stall", if_stall, 1); chk("s_d_stall_ack", d_stall, 0);
    d_req = 0;
    tick();
    chk("s_m_en_fetch", m_en, 1); chk("s_m_addr_fetch", m_addr, 32'h14); chk("s_m_func_fetch", m_func, 3'b010);
    repeat (LAT) tick();
    tick();
    chk("s_if_ack", if_ack, 1); chk("s_if_rdata", if_rdata, 32'h00a0_0113);
    if_req = 0;
    tick();

    // Store; late changes to requester fields are ignored
    tick();
    d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'hDEAD_BEEF; d_func = 3'b010;
    tick();
    chk("st_m_en", m_en, 1); chk("st_m_we", m_we, 1); chk("st_m_wdata", m_wdata, 32'hDEAD_BEEF);
    chk("st_m_func", m_func, 3'b010); chk("st_m_addr", m_addr, 32'h80);
    d_wdata = 32'h0BAD_F00D; d_addr = 32'h84;
    repeat (LAT) tick();
    chk("st_wdata_held", m_wdata, 32'hDEAD_BEEF); chk("st_addr_held", m_addr, 32'h80);
    tick();
    chk("st_d_ack", d_ack, 1); chk("st_d_rdata_unchanged", d_rdata, 32'h1234_5678);
    d_req = 0; d_we = 0;
    tick();
    d_req = 1; d_addr = 32'h80; d_func = 3'b010;
    repeat (LAT + 2) tick();
    chk("st_readback_ack", d_ack, 1); chk("st_readback", d_rdata, 32'hDEAD_BEEF);
    d_req = 0;
    tick();

    // Reset during WAIT
    mem[32'h20] = 32'h1111_2222; mem[32'h24] = 32'h3333_4444;
    tick();
    if_req = 1; if_addr = 32'h20;
    tick(); tick(); tick();
    rst = 1'b1; #1;
    chk_all_zero("rst_wait");
    if_req = 0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < LAT + 4; i++) begin
      tick();
      chk("rst_no_if_ack", if_ack, 0); chk("rst_no_d_ack", d_ack, 0); chk("rst_no_m_en", m_en, 0);
    end
    if_req = 1; if_addr = 32'h24;
    for (int k = 1; k <= LAT + 2; k++) begin
      tick();
      chk("rst_new_fetch_ack", if_ack, (k == LAT + 2) ? 1 : 0);
    end
    chk("rst_new_fetch_rdata", if_rdata, 32'h3333_4444);
    if_req = 0;
    tick();

    // Fetch request held across three fetches; PC advances on each ack
    for (int k = 0; k < 3; k++) mem[32'h200 + 4 * k] = 32'hA000_0000 + k;
    tick();
    if_req = 1; if_addr = 32'h200; ack_n = 0;
    for (int c = 1; c <= 3 * LAT + 8; c++) begin
      tick();
      exp_f = (c == (ack_n + 1) * (LAT + 2) + ack_n);
      chk("held_if_ack", if_ack, exp_f);
      if (exp_f) begin
        chk("held_if_rdata", if_rdata, 32'hA000_0000 + ack_n);
        ack_n++;
        if_addr = if_addr + 4;
        if (ack_n == 3) if_req = 0;
      end
    end
    chk("held_count", ack_n, 3);
    tick();

    // Randomized traffic against a transaction-level model
    for (int k = 0; k < 16; k++) begin
      v = $urandom;
      mem[32'h300 + 4 * k] = v;
      ref_mem[32'h300 + 4 * k] = v;
    end
    mbusy = 0; starve = 0; f_act = 0; d_act = 0; mgrant = 0; mdone = 0; mown = 0;
    maddr = 0; mwe = 0; mwdata = 0; mfunc = 0;
    for (int it = 0; it < 700; it++) begin
      tick();
      exp_f = mbusy && (cyc == mdone) && (mown == 1'b0);
      exp_d = mbusy && (cyc == mdone) && (mown == 1'b1);
      chk("rnd_if_ack", if_ack, exp_f);
      chk("rnd_d_ack", d_ack, exp_d);
      chk("rnd_m_en", m_en, mbusy && (cyc == mgrant + 1));
      if (mbusy && (cyc == mgrant + 1)) begin
        chk("rnd_m_addr", m_addr, maddr); chk("rnd_m_we", m_we, mwe); chk("rnd_m_func", m_func, mfunc);
        if (mwe) chk("rnd_m_wdata", m_wdata, mwdata);
      end
      if (exp_f) begin
        chk("rnd_if_rdata", if_rdata, ref_mem[maddr]);
        f_act = 0; if_req = 0;
      end
      if (exp_d) begin
        if (mwe) ref_mem[maddr] = mwdata;
        else chk("rnd_d_rdata", d_rdata, ref_mem[maddr]);
        d_act = 0; d_req = 0;
      end
      if (it < 600) begin
        if (!f_act && ($urandom_range(2) == 0)) begin
          f_act = 1; if_req = 1; if_addr = 32'h300 + 4 * $urandom_range(15);
        end
        if (!d_act && ($urandom_range(2) == 0)) begin
          d_act = 1; d_req = 1; d_we = 1'($urandom_range(1)); d_func = 3'($urandom_range(7));
          d_addr = 32'h300 + 4 * $urandom_range(15); d_wdata = $urandom;
        end
      end
      #1;
      chk("rnd_if_stall", if_stall, if_req && !exp_f);
      chk("rnd_d_stall", d_stall, d_req && !exp_d);
      // Port free this cycle? The requester just acked is not eligible until the next cycle.
      mask = 0;
      if (mbusy && (cyc == mdone)) begin
        mbusy = 0;
        mask = (mown == 1'b0) ? 1 : 2;
      end
      if (!mbusy) begin
        ef = if_req && (mask != 1);
        ed = d_req && (mask != 2);
        if (ef || ed) begin
          take_f = ef && (!ed || (starve == SMAX));
          if (take_f) starve = 0;
          else if (if_req && (starve < SMAX)) starve++;
          mbusy = 1; mgrant = cyc; mdone = cyc + LAT + 2;
          mown = take_f ? 1'b0 : 1'b1;
          maddr = take_f ? if_addr : d_addr;
          mwe = take_f ? 1'b0 : d_we;
          mfunc = take_f ? 3'b010 : d_func;
          mwdata = d_wdata;
        end
      end
      if ((it >= 600) && !f_act && !d_act && !mbusy) break;
    end
    chk("rnd_drained", {29'd0, f_act, d_act, mbusy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
